// File: rtl/logic_chk_pkg.sv
// logic_chk_pkg: shared state encoding, gate bit positions and golden gate model
package logic_chk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int NOT_B  = 0;
  localparam int AND_B  = 1;
  localparam int OR_B   = 2;
  localparam int NAND_B = 3;
  localparam int NOR_B  = 4;
  localparam int XOR_B  = 5;
  localparam int XNOR_B = 6;
  function automatic logic [6:0] golden_gates(input logic a, input logic b);
    logic [6:0] g;
    g[NOT_B]  = ~a;
    g[AND_B]  = a & b;
    g[OR_B]   = a | b;
    g[NAND_B] = ~(a & b);
    g[NOR_B]  = ~(a | b);
    g[XOR_B]  = a ^ b;
    g[XNOR_B] = ~(a ^ b);
    return g;
  endfunction
endpackage

// File: rtl/logic_checker.sv
// logic_checker: compares registered gate outputs against a golden model over a run of samples
module logic_checker
  import logic_chk_pkg::*;
#(
  parameter int NUM_SAMPLES = 16,
  parameter int ERR_W = 8,
  localparam int CNT_W = $clog2(NUM_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic [6:0]       g_vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       first_err_vec,
  output logic [CNT_W-1:0] first_err_idx
);
  state_t state, state_n;
  logic a_q, b_q, v_q, first_seen, go, last;
  logic [CNT_W-1:0] sample_cnt;
  logic [6:0] mism;
  assign go = start && (state == IDLE || state == DONE);
  assign last = sample_cnt == CNT_W'(NUM_SAMPLES - 1);
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  always_comb begin
    mism = v_q ? g_vec ^ golden_gates(a_q, b_q) : 7'b0;
    state_n = go ? RUN : state == RUN ? (last ? DRAIN : RUN) : state == DRAIN ? DONE : state;
  end
  // sample_cnt keeps counting through the last RUN edge, so the sample under compare is always sample_cnt-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      a_q <= 1'b0;
      b_q <= 1'b0;
      v_q <= 1'b0;
      first_seen <= 1'b0;
      sample_cnt <= '0;
      err_count <= '0;
      first_err_vec <= '0;
      first_err_idx <= '0;
    end else begin
      state <= state_n;
      v_q <= state == RUN;
      if (state == RUN) begin
        a_q <= a;
        b_q <= b;
      end
      if (go) begin
        sample_cnt <= '0;
        err_count <= '0;
        first_err_vec <= '0;
        first_err_idx <= '0;
        first_seen <= 1'b0;
      end else begin
        if (state == RUN) sample_cnt <= sample_cnt + 1'b1;
        if (|mism) begin
          if (!(&err_count)) err_count <= err_count + 1'b1;
          if (!first_seen) begin
            first_err_vec <= mism;
            first_err_idx <= sample_cnt - 1'b1;
            first_seen <= 1'b1;
          end
        end
      end
    end
  end
endmodule
